// File: rtl/gpio_cfg_pkg.sv
// gpio_cfg_pkg: shared GPIO pad configuration word layout.
package gpio_cfg_pkg;
    localparam int GPIO_CFG_W   = 10;
    localparam int CFG_MGMT_ENA = 0;
    localparam int CFG_OUTENB   = 1;
    localparam int CFG_INP_DIS  = 2;
    localparam int CFG_PU       = 3;
    localparam int CFG_PD       = 4;
    localparam int CFG_SCHMITT  = 5;
    localparam int CFG_SLEW     = 6;
    localparam int CFG_DRIVE_LO = 7;
    localparam int CFG_DRIVE_HI = 8;
    localparam int CFG_HOLD     = 9;

    typedef struct packed {
        logic       hold;
        logic [1:0] drive;
        logic       slew;
        logic       schmitt;
        logic       pd;
        logic       pu;
        logic       inp_dis;
        logic       outenb;
        logic       mgmt_ena;
    } gpio_cfg_t;
endpackage

// File: rtl/gpio_config_shift.sv
// gpio_config_shift: per-pad live GPIO config, loaded from tie-cell defaults or a serial daisy chain.
module gpio_config_shift
    import gpio_cfg_pkg::*;
#(
    parameter int WIDTH = GPIO_CFG_W,
    parameter int CNT_W = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [WIDTH-1:0] gpio_defaults,
    input  logic             serial_data_in,
    input  logic             serial_shift,
    input  logic             serial_load,
    input  logic             serial_resync,
    output logic             serial_data_out,
    output logic [WIDTH-1:0] gpio_config,
    output logic             mgmt_ena,
    output logic             gpio_outenb,
    output logic             gpio_inp_dis,
    output logic             gpio_pu,
    output logic             gpio_pd,
    output logic             gpio_schmitt,
    output logic             gpio_slew,
    output logic [1:0]       gpio_drive,
    output logic             gpio_hold,
    output logic             load_err
);
    logic [WIDTH-1:0] shift_q, shift_d, cfg_q, cfg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Load samples the pre-edge shift register and count, so a simultaneous shift does not leak in.
    always_comb begin
        shift_d = shift_q;
        cfg_d   = cfg_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        if (serial_resync) begin
            shift_d = gpio_defaults;
            cfg_d   = gpio_defaults;
            cnt_d   = '0;
        end else begin
            if (serial_shift) begin
                shift_d = {shift_q[WIDTH-2:0], serial_data_in};
                cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            end
            if (serial_load) begin
                cfg_d = shift_q;
                err_d = cnt_q != CNT_W'(WIDTH);
                cnt_d = serial_shift ? CNT_W'(1) : '0;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            shift_q <= gpio_defaults;
            cfg_q   <= gpio_defaults;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign serial_data_out = shift_q[WIDTH-1];
    assign gpio_config     = cfg_q;
    assign load_err        = err_q;
    assign mgmt_ena        = cfg_q[CFG_MGMT_ENA];
    assign gpio_outenb     = cfg_q[CFG_OUTENB];
    assign gpio_inp_dis    = cfg_q[CFG_INP_DIS];
    assign gpio_pu         = cfg_q[CFG_PU];
    assign gpio_pd         = cfg_q[CFG_PD];
    assign gpio_schmitt    = cfg_q[CFG_SCHMITT];
    assign gpio_slew       = cfg_q[CFG_SLEW];
    assign gpio_drive      = cfg_q[CFG_DRIVE_HI:CFG_DRIVE_LO];
    assign gpio_hold       = cfg_q[CFG_HOLD];
endmodule

// File: tb/tb_gpio_config_shift.sv
// tb_gpio_config_shift: directed and randomized checks of one pad plus a three-pad chain.
module tb_gpio_config_shift;
    logic       clk = 1'b0;
    logic       rst, sdi, sh, ld, rs, c_sdi;
    logic [9:0] def;
    logic       sdo, mgmt, oeb, idis, pu, pd, sch, slew, hold, err;
    logic [1:0] drv;
    logic [9:0] cfg;
    logic [2:0] c_sdo, c_err;
    logic [9:0] c_cfg [3];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain integers and arithmetic
    int         m_shift, m_cfg, m_cnt;
    logic       m_err;
    logic [29:0] m_ch;

    always #5 clk = ~clk;

    gpio_config_shift dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .gpio_defaults(def),
        .serial_data_in(sdi), .serial_shift(sh), .serial_load(ld), .serial_resync(rs),
        .serial_data_out(sdo), .gpio_config(cfg),
        .mgmt_ena(mgmt), .gpio_outenb(oeb), .gpio_inp_dis(idis), .gpio_pu(pu), .gpio_pd(pd),
        .gpio_schmitt(sch), .gpio_slew(slew), .gpio_drive(drv), .gpio_hold(hold),
        .load_err(err)
    );

    for (genvar g = 0; g < 3; g++) begin : g_chain
        logic c_in;
        logic       u_mg, u_oe, u_id, u_pu, u_pd, u_sc, u_sl, u_ho;
        logic [1:0] u_dr;
        assign c_in = (g == 0) ? c_sdi : c_sdo[(g == 0) ? 0 : g - 1];
        gpio_config_shift u_pad (
            .wb_clk_i(clk), .wb_rst_i(rst), .gpio_defaults(def),
            .serial_data_in(c_in), .serial_shift(sh), .serial_load(ld), .serial_resync(rs),
            .serial_data_out(c_sdo[g]), .gpio_config(c_cfg[g]),
            .mgmt_ena(u_mg), .gpio_outenb(u_oe), .gpio_inp_dis(u_id), .gpio_pu(u_pu), .gpio_pd(u_pd),
            .gpio_schmitt(u_sc), .gpio_slew(u_sl), .gpio_drive(u_dr), .gpio_hold(u_ho),
            .load_err(c_err[g])
        );
    end

    function automatic void model_step();
        int old_shift, old_cnt;
        old_shift = m_shift;
        old_cnt   = m_cnt;
        m_err     = 1'b0;
        if (rst || rs) begin
            m_shift = int'(def);
            m_cfg   = int'(def);
            m_cnt   = 0;
            return;
        end
        if (sh) begin
            m_shift = (m_shift * 2 + int'(sdi)) % 1024;
            m_cnt   = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
        end
        if (ld) begin
            m_cfg = old_shift;
            m_err = (old_cnt != 10);
            m_cnt = sh ? 1 : 0;
        end
    endfunction

    task automatic tick(input logic s, input logic l, input logic r, input logic d);
        sh = s; ld = l; rs = r; sdi = d;
        model_step();
        @(posedge clk);
        #1;
        sh = 1'b0; ld = 1'b0; rs = 1'b0;
    endtask

    task automatic do_reset(input logic [9:0] dv);
        def = dv; rst = 1'b1;
        tick(0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic shift_word(input logic [9:0] w, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) tick(1, 0, 0, w[i]);
    endtask

    task automatic test_reset();
        do_reset(10'h007);
        n_cmp++; if (cfg !== 10'h007) begin n_err++; $display("FAIL reset_cfg got=%h exp=%h", cfg, 10'h007); end
        n_cmp++; if ({mgmt, oeb, idis} !== 3'b111) begin n_err++; $display("FAIL reset_fields got=%b exp=111", {mgmt, oeb, idis}); end
        n_cmp++; if (sdo !== 1'b0) begin n_err++; $display("FAIL reset_sdo got=%b exp=0", sdo); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", err); end
    endtask

    task automatic test_full_load();
        shift_word(10'h2A5, 10);
        n_cmp++; if (cfg !== 10'h007) begin n_err++; $display("FAIL shift_no_disturb got=%h exp=%h", cfg, 10'h007); end
        n_cmp++; if (sdo !== 1'b1) begin n_err++; $display("FAIL shift_sdo got=%b exp=1", sdo); end
        tick(0, 1, 0, 0);
        n_cmp++; if (cfg !== 10'h2A5) begin n_err++; $display("FAIL full_load_cfg got=%h exp=%h", cfg, 10'h2A5); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL full_load_err got=%b exp=0", err); end
    endtask

    task automatic test_short_load();
        logic [9:0] exp;
        do_reset(10'h007);
        shift_word(10'h05A, 7);
        exp = 10'((10'h007 << 7) | 10'h05A);
        tick(0, 1, 0, 0);
        n_cmp++; if (cfg !== exp) begin n_err++; $display("FAIL short_load_cfg got=%h exp=%h", cfg, exp); end
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL short_load_err got=%b exp=1", err); end
        tick(0, 0, 0, 0);
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL short_err_pulse got=%b exp=0", err); end
        shift_word(10'h1C3, 10);
        tick(0, 1, 0, 0);
        n_cmp++; if (err !== 1'b0 || cfg !== 10'h1C3) begin n_err++; $display("FAIL count_cleared got=%b/%h exp=0/%h", err, cfg, 10'h1C3); end
    endtask

    task automatic test_shift_and_load();
        shift_word(10'h155, 10);
        tick(1, 1, 0, 1'b1);
        n_cmp++; if (cfg !== 10'h155) begin n_err++; $display("FAIL sl_cfg got=%h exp=%h", cfg, 10'h155); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL sl_err got=%b exp=0", err); end
        shift_word(10'h0F0, 9);
        tick(0, 1, 0, 0);
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL sl_count_one got=%b exp=0", err); end
        n_cmp++; if (cfg !== 10'h2F0) begin n_err++; $display("FAIL sl_after_cfg got=%h exp=%h", cfg, 10'h2F0); end
    endtask

    task automatic test_resync();
        def = 10'h0C3;
        shift_word(10'h3FF, 10);
        tick(0, 1, 1, 0);
        n_cmp++; if (cfg !== 10'h0C3) begin n_err++; $display("FAIL resync_cfg got=%h exp=%h", cfg, 10'h0C3); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL resync_err got=%b exp=0", err); end
        n_cmp++; if (sdo !== 1'b0) begin n_err++; $display("FAIL resync_sdo got=%b exp=0", sdo); end
        tick(0, 1, 0, 0);
        n_cmp++; if (cfg !== 10'h0C3 || err !== 1'b1) begin n_err++; $display("FAIL resync_shreg got=%h/%b exp=%h/1", cfg, err, 10'h0C3); end
    endtask

    task automatic test_overlong();
        do_reset(10'h000);
        shift_word(10'h3A5, 10);
        shift_word(10'h16B, 10);
        tick(0, 1, 0, 0);
        n_cmp++; if (cfg !== 10'h16B || err !== 1'b1) begin n_err++; $display("FAIL overlong got=%h/%b exp=%h/1", cfg, err, 10'h16B); end
    endtask

    task automatic test_chain();
        logic [29:0] stream;
        do_reset(10'h2C1);
        m_ch   = {def, def, def};
        stream = 30'($urandom);
        for (int i = 29; i >= 0; i--) begin
            c_sdi = stream[i];
            tick(1, 0, 0, 0);
            m_ch = {m_ch[28:0], stream[i]};
            n_cmp++; if (c_sdo[0] !== m_ch[9]) begin n_err++; $display("FAIL chain_sdo0 step=%0d got=%b exp=%b", i, c_sdo[0], m_ch[9]); end
        end
        n_cmp++; if (c_cfg[0] !== 10'h2C1) begin n_err++; $display("FAIL chain_pre_load got=%h exp=%h", c_cfg[0], 10'h2C1); end
        tick(0, 1, 0, 0);
        for (int p = 0; p < 3; p++) begin
            n_cmp++;
            if (c_cfg[p] !== stream[p*10 +: 10]) begin n_err++; $display("FAIL chain_pad%0d got=%h exp=%h", p, c_cfg[p], stream[p*10 +: 10]); end
        end
        n_cmp++; if (c_err !== 3'b111) begin n_err++; $display("FAIL chain_err got=%b exp=111", c_err); end
    endtask

    task automatic test_random();
        logic [9:0] fields;
        do_reset(10'($urandom));
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) def = 10'($urandom);
            tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 29) == 0), 1'($urandom));
            rst = 1'b0;
            fields = {hold, drv, slew, sch, pd, pu, idis, oeb, mgmt};
            n_cmp++;
            if (cfg !== 10'(m_cfg) || fields !== 10'(m_cfg) || sdo !== 1'(m_shift >> 9) || err !== m_err) begin
                n_err++;
                $display("FAIL random cyc=%0d got cfg=%h fld=%h sdo=%b err=%b exp cfg=%h sdo=%b err=%b",
                         i, cfg, fields, sdo, err, 10'(m_cfg), 1'(m_shift >> 9), m_err);
            end
        end
    endtask

    initial begin
        rst = 1'b0; sdi = 1'b0; sh = 1'b0; ld = 1'b0; rs = 1'b0; c_sdi = 1'b0; def = '0;
        m_shift = 0; m_cfg = 0; m_cnt = 0; m_err = 1'b0; m_ch = '0;
        #1;
        test_reset();
        test_full_load();
        test_short_load();
        test_shift_and_load();
        test_resync();
        test_overlong();
        test_chain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
